// File: rtl/qspi_arb.sv
// qspi_arb: round-robin line-transfer arbiter in front of the single QSPI
// controller. Three requesters share it: icache refill (i), dcache
// refill/write-back (d) and the future SD/DMA engine (x). The winner's tag,
// direction and rom/ram select are held for the whole line. Strobes are
// steered back only to the granted port. A watchdog frees the bus if the
// controller never signals completion.
module qspi_arb #(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int TMO         = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    // icache refill port (read only)
    input  logic                              i_req,
    input  logic                              i_mem,
    input  logic [PA-1:$clog2(LINE_LENGTH)]   i_tag,
    output logic                              i_gnt,
    output logic                              i_wstrobe,
    // dcache refill / write-back port
    input  logic                              d_req,
    input  logic                              d_write,
    input  logic                              d_mem,
    input  logic [PA-1:$clog2(LINE_LENGTH)]   d_tag,
    input  logic [3:0]                        d_dwrite,
    output logic                              d_gnt,
    output logic                              d_wstrobe,
    output logic                              d_rstrobe,
    // reserved SD/DMA port
    input  logic                              x_req,
    input  logic                              x_write,
    input  logic                              x_mem,
    input  logic [PA-1:$clog2(LINE_LENGTH)]   x_tag,
    input  logic [3:0]                        x_dwrite,
    output logic                              x_gnt,
    output logic                              x_wstrobe,
    output logic                              x_rstrobe,
    // towards the QSPI controller
    output logic                              q_req,
    output logic                              q_i_d,
    output logic                              q_mem,
    output logic                              q_write,
    output logic [PA-1:$clog2(LINE_LENGTH)]   q_paddr,
    output logic [3:0]                        q_dwrite,
    input  logic                              q_wstrobe,
    input  logic                              q_rstrobe,
    input  logic                              q_done,
    // watchdog expiry pulse
    output logic                              err
);

    localparam int LB = $clog2(LINE_LENGTH);
    // At least 8 bits, wider only if the limit needs it.
    localparam int CW = (TMO > 255) ? $clog2(TMO + 1) : 8;
    // The counter reads 0 in the first busy cycle, so the limit is hit
    // when it shows TMO-1 (i.e. in the TMO-th busy cycle).
    localparam logic [CW-1:0] TMO_LAST = (TMO == 0) ? '0 : CW'(TMO - 1);

    localparam logic [1:0] ID_D = 2'd0;
    localparam logic [1:0] ID_I = 2'd1;
    localparam logic [1:0] ID_X = 2'd2;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_id;
    logic [1:0]          r_last;
    logic [PA-1:LB]      r_tag;
    logic                r_write;
    logic                r_mem;
    logic [CW-1:0]       r_cnt;

    logic                w_win_vld;
    logic [1:0]          w_win_id;
    logic [PA-1:LB]      w_win_tag;
    logic                w_win_write;
    logic                w_win_mem;
    logic                w_tmo;
    logic                w_end;

    assign w_tmo = (TMO != 0) && (r_state == S_BUSY) && (r_cnt == TMO_LAST);
    assign w_end = (r_state == S_BUSY) && (q_done || w_tmo);

    // Round-robin pick over the ring d -> i -> x -> d, starting after r_last.
    always_comb begin
        w_win_vld = d_req | i_req | x_req;
        w_win_id  = ID_D;
        case (r_last)
            ID_D: begin
                if (i_req)      w_win_id = ID_I;
                else if (x_req) w_win_id = ID_X;
                else            w_win_id = ID_D;
            end
            ID_I: begin
                if (x_req)      w_win_id = ID_X;
                else if (d_req) w_win_id = ID_D;
                else            w_win_id = ID_I;
            end
            default: begin
                if (d_req)      w_win_id = ID_D;
                else if (i_req) w_win_id = ID_I;
                else            w_win_id = ID_X;
            end
        endcase
    end

    // Select the winner's transfer attributes; the i port never writes.
    always_comb begin
        w_win_tag   = d_tag;
        w_win_write = d_write;
        w_win_mem   = d_mem;
        case (w_win_id)
            ID_I: begin
                w_win_tag   = i_tag;
                w_win_write = 1'b0;
                w_win_mem   = i_mem;
            end
            ID_X: begin
                w_win_tag   = x_tag;
                w_win_write = x_write;
                w_win_mem   = x_mem;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: arbitrate only from IDLE, so the cycle after a completion
    // is always idle and the cache can drop a request it no longer needs.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_win_vld) w_next = S_BUSY;
            S_BUSY: if (w_end)     w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Transfer latches, last-granted pointer and watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id    <= ID_D;
            r_last  <= ID_X;
            r_tag   <= '0;
            r_write <= 1'b0;
            r_mem   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_win_vld) begin
                r_id    <= w_win_id;
                r_tag   <= w_win_tag;
                r_write <= w_win_write;
                r_mem   <= w_win_mem;
                r_cnt   <= '0;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_end) r_last <= r_id;
        end
    end

    // Outputs: everything quiet in IDLE; in BUSY drive the controller from
    // the latches and steer strobes / write data for the granted port only.
    always_comb begin
        i_gnt     = 1'b0;
        i_wstrobe = 1'b0;
        d_gnt     = 1'b0;
        d_wstrobe = 1'b0;
        d_rstrobe = 1'b0;
        x_gnt     = 1'b0;
        x_wstrobe = 1'b0;
        x_rstrobe = 1'b0;
        q_req     = 1'b0;
        q_i_d     = 1'b0;
        q_mem     = 1'b0;
        q_write   = 1'b0;
        q_paddr   = '0;
        q_dwrite  = 4'h0;
        err       = 1'b0;
        if (r_state == S_BUSY) begin
            q_req   = 1'b1;
            q_paddr = r_tag;
            q_write = r_write;
            q_mem   = r_mem & ~r_write;
            q_i_d   = (r_id == ID_I);
            err     = w_tmo & ~q_done;
            case (r_id)
                ID_D: begin
                    d_gnt     = 1'b1;
                    d_wstrobe = q_wstrobe;
                    d_rstrobe = q_rstrobe;
                    q_dwrite  = d_dwrite;
                end
                ID_I: begin
                    i_gnt     = 1'b1;
                    i_wstrobe = q_wstrobe;
                end
                ID_X: begin
                    x_gnt     = 1'b1;
                    x_wstrobe = q_wstrobe;
                    x_rstrobe = q_rstrobe;
                    q_dwrite  = x_dwrite;
                end
                default: ;
            endcase
        end
    end

endmodule
